// File: rtl/map_mem_write_arbiter_if.sv
// Write-request bundle between tile writers and the map memory write arbiter.
// The master side drives per-requester requests; the slave side (arbiter) drives the write port.
interface map_mem_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
);
  logic [NUM_REQ-1:0]    wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr_req [0:NUM_REQ-1];
  logic [DATA_WIDTH-1:0] wr_data_req [0:NUM_REQ-1];
  logic [NUM_REQ-1:0]    wr_granted;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  collision;

  modport master (
    output wr_req, wr_addr_req, wr_data_req,
    input  wr_granted, we, wr_addr, wr_data, collision
  );

  modport slave (
    input  wr_req, wr_addr_req, wr_data_req,
    output wr_granted, we, wr_addr, wr_data, collision
  );
endinterface

// File: rtl/map_mem_write_arbiter.sv
// Round-robin write arbiter for the map memory write port with one-arbitration grant masking.
// Define MAP_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
//
// state    | meaning
// ST_IDLE  | no write issued this cycle (we=0)
// ST_WRITE | write issued this cycle (we=1), mask holds the granted requester
module map_mem_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  map_mem_write_arbiter_if.slave bus_if
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    mask_q, mask_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  coll_q, coll_d;
  logic [NUM_REQ-1:0]    elig;
  logic [IDX_W-1:0]      win;
  logic                  found;
  int                    idx;
  int                    nxt;
`ifndef MAP_WR_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      coll_q   <= 1'b0;
`ifndef MAP_WR_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      coll_q   <= coll_d;
`ifndef MAP_WR_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    elig    = bus_if.wr_req & ~mask_q;
    state_d = ST_IDLE;
    mask_d  = '0;
    grant_d = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    coll_d  = 1'b0;
    found   = 1'b0;
    win     = '0;
    idx     = 0;
    nxt     = 0;
`ifndef MAP_WR_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif

    // Scan starting at the pointer (or at 0 for fixed priority), wrapping once.
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MAP_WR_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!found && elig[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end

    if (found) begin
      state_d      = ST_WRITE;
      mask_d[win]  = 1'b1;
      grant_d[win] = 1'b1;
      addr_d       = bus_if.wr_addr_req[win];
      data_d       = bus_if.wr_data_req[win];
      nxt          = int'(win) + 1;
      if (nxt >= NUM_REQ) nxt = 0;
`ifndef MAP_WR_ARB_FIXED_PRIO_EN
      rr_ptr_d     = IDX_W'(nxt);
`endif
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (elig[IDX_W'(i)] && elig[IDX_W'(j)] &&
            (bus_if.wr_addr_req[IDX_W'(i)] == bus_if.wr_addr_req[IDX_W'(j)]))
          coll_d = 1'b1;
      end
    end
  end

  assign bus_if.we         = (state_q == ST_WRITE);
  assign bus_if.wr_granted = grant_q;
  assign bus_if.wr_addr    = addr_q;
  assign bus_if.wr_data    = data_q;
  assign bus_if.collision  = coll_q;
endmodule
